// File: rtl/regfile_pkg.sv
// Shared widths and requester indices for the register-file write path.
package regfile_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    // Bit positions in the two-bit valid/grant vectors.
    localparam logic REQ_ALU  = 1'b0;
    localparam logic REQ_LOAD = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; owns the last_grant pointer.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       cclk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            if (valid == 2'b11) begin
                grant = (last_grant_q == REQ_LOAD) ? 2'b01 : 2'b10;
            end else begin
                grant = valid;
            end
        end

        // Grants are never given without valid, so a grant bit marks a transfer.
        last_grant_d = last_grant_q;
        if (grant[REQ_LOAD]) begin
            last_grant_d = REQ_LOAD;
        end else if (grant[REQ_ALU]) begin
            last_grant_d = REQ_ALU;
        end
    end

    always_ff @(posedge cclk) begin
        if (rst) begin
            last_grant_q <= REQ_LOAD;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register_file write port between ALU and load writeback,
// and forwards the in-flight write onto both decode read ports.
module regfile_write_arbiter #(
    parameter int unsigned DATA_W = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              cclk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_reg,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_reg,
    input  logic [DATA_W-1:0] req1_data,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [ADDR_W-1:0] read_reg_0,
    input  logic [ADDR_W-1:0] read_reg_1,
    input  logic [DATA_W-1:0] rf_reg0,
    input  logic [DATA_W-1:0] rf_reg1,
    output logic [DATA_W-1:0] rd_data_0,
    output logic [DATA_W-1:0] rd_data_1
);

    logic [1:0]        valid;
    logic [1:0]        grant;
    logic              xfer;
    logic [ADDR_W-1:0] wr_reg;
    logic [DATA_W-1:0] wr_data;

    logic              rf_write_q, rf_write_d;
    logic [ADDR_W-1:0] rf_write_reg_q, rf_write_reg_d;
    logic [DATA_W-1:0] rf_write_data_q, rf_write_data_d;

    assign valid = {req1_valid, req0_valid};

    rr_arbiter2 u_arb (
        .cclk  (cclk),
        .rst   (rst),
        .valid (valid),
        .grant (grant)
    );

    assign req0_ready = grant[regfile_pkg::REQ_ALU];
    assign req1_ready = grant[regfile_pkg::REQ_LOAD];

    always_comb begin
        xfer    = |grant;
        wr_reg  = grant[regfile_pkg::REQ_LOAD] ? req1_reg  : req0_reg;
        wr_data = grant[regfile_pkg::REQ_LOAD] ? req1_data : req0_data;

        // Writes to $zero are accepted but never reach the register file.
        rf_write_d      = xfer && (wr_reg != ADDR_W'(regfile_pkg::ZERO_REG));
        rf_write_reg_d  = xfer ? wr_reg  : rf_write_reg_q;
        rf_write_data_d = xfer ? wr_data : rf_write_data_q;
    end

    always_ff @(posedge cclk) begin
        if (rst) begin
            rf_write_q      <= 1'b0;
            rf_write_reg_q  <= '0;
            rf_write_data_q <= '0;
        end else begin
            rf_write_q      <= rf_write_d;
            rf_write_reg_q  <= rf_write_reg_d;
            rf_write_data_q <= rf_write_data_d;
        end
    end

    // Masking with rst keeps a write issued just before reset from committing.
    assign rf_write      = rf_write_q && !rst;
    assign rf_write_reg  = rf_write_reg_q;
    assign rf_write_data = rf_write_data_q;

    function automatic logic [DATA_W-1:0] fwd(input logic [ADDR_W-1:0] idx,
                                              input logic [DATA_W-1:0] rf_val);
        if (idx == ADDR_W'(regfile_pkg::ZERO_REG)) begin
            return '0;
        end else if (rf_write && (rf_write_reg == idx)) begin
            return rf_write_data;
        end
        return rf_val;
    endfunction

    assign rd_data_0 = fwd(read_reg_0, rf_reg0);
    assign rd_data_1 = fwd(read_reg_1, rf_reg1);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: stimulus queues expected writes, a monitor checks each rf_write.
module tb_regfile_write_arbiter;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    logic        cclk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [4:0]  req0_reg, req1_reg, rf_write_reg, read_reg_0, read_reg_1;
    logic [31:0] req0_data, req1_data, rf_write_data, rf_reg0, rf_reg1, rd_data_0, rd_data_1;
    logic        rf_write;

    logic [31:0] rf_mem [32];
    wr_t         exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 cclk = ~cclk;

    regfile_write_arbiter dut (
        .cclk          (cclk),
        .rst           (rst),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_reg      (req0_reg),
        .req0_data     (req0_data),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_reg      (req1_reg),
        .req1_data     (req1_data),
        .rf_write      (rf_write),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .read_reg_0    (read_reg_0),
        .read_reg_1    (read_reg_1),
        .rf_reg0       (rf_reg0),
        .rf_reg1       (rf_reg1),
        .rd_data_0     (rd_data_0),
        .rd_data_1     (rd_data_1)
    );

    // Behavioural register_file: rN starts out holding N.
    assign rf_reg0 = rf_mem[read_reg_0];
    assign rf_reg1 = rf_mem[read_reg_1];

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] <= 32'(i);
        forever begin
            @(posedge cclk);
            if (rf_write) rf_mem[rf_write_reg] <= rf_write_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every committed write must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(posedge cclk);
            #2;
            if (rf_write) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got reg %0d data %0h expected none at %0t",
                             rf_write_reg, rf_write_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_reg", 32'(rf_write_reg), 32'(e.r));
                    check("wr_data", rf_write_data, e.d);
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic v0, input logic [4:0] g0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] g1, input logic [31:0] d1,
                       input logic e0, input logic e1);
        @(negedge cclk);
        rst = r;
        req0_valid = v0; req0_reg = g0; req0_data = d0;
        req1_valid = v1; req1_reg = g1; req1_data = d1;
        #1;
        check("req0_ready", 32'(req0_ready), 32'(e0));
        check("req1_ready", 32'(req1_ready), 32'(e1));
        if (e0 && g0 != 5'd0) exp_q.push_back('{r: g0, d: d0});
        if (e1 && g1 != 5'd0) exp_q.push_back('{r: g1, d: d1});
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req0_reg = 5'd1; req0_data = 32'd11;
        req1_valid = 1'b1; req1_reg = 5'd2; req1_data = 32'd22;
        read_reg_0 = 5'd0; read_reg_1 = 5'd0;

        // Reset with both requesters holding valid.
        repeat (2) cyc(1'b1, 1'b1, 5'd1, 32'd11, 1'b1, 5'd2, 32'd22, 1'b0, 1'b0);
        check("rst_rf_write", 32'(rf_write), 32'd0);
        check("rst_wr_reg", 32'(rf_write_reg), 32'd0);
        check("rst_wr_data", rf_write_data, 32'd0);
        cyc(1'b0, 1'b1, 5'd1, 32'd11, 1'b1, 5'd2, 32'd22, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'd22, 1'b0, 1'b1);

        // Solo load write, then forward and committed read of r5.
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'd8, 1'b0, 1'b1);
        idle();
        read_reg_0 = 5'd5;
        #1 check("fwd_r5", rd_data_0, 32'd8);
        idle();
        #1 check("rf_r5", rd_data_0, 32'd8);

        // Contention: last grant was req1, so grants run 0,1,0,1.
        cyc(1'b0, 1'b1, 5'd10, 32'd100, 1'b1, 5'd20, 32'd200, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 5'd11, 32'd101, 1'b1, 5'd20, 32'd200, 1'b0, 1'b1);
        check("contend_wr1", 32'(rf_write), 32'd1);
        cyc(1'b0, 1'b1, 5'd11, 32'd101, 1'b1, 5'd21, 32'd201, 1'b1, 1'b0);
        check("contend_wr2", 32'(rf_write), 32'd1);
        cyc(1'b0, 1'b1, 5'd12, 32'd102, 1'b1, 5'd21, 32'd201, 1'b0, 1'b1);
        check("contend_wr3", 32'(rf_write), 32'd1);
        idle();
        check("contend_wr4", 32'(rf_write), 32'd1);

        // Write to $zero is accepted but not issued.
        cyc(1'b0, 1'b1, 5'd0, 32'd1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        idle();
        check("zero_no_write", 32'(rf_write), 32'd0);
        read_reg_0 = 5'd0;
        #1 check("zero_read", rd_data_0, 32'd0);

        // Forwarding of an in-flight r3 write on read port 1.
        cyc(1'b0, 1'b1, 5'd3, 32'd21, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        idle();
        read_reg_1 = 5'd3;
        #1 check("fwd_r3", rd_data_1, 32'd21);
        read_reg_1 = 5'd30;
        #1 check("nofwd_r30", rd_data_1, 32'd30);
        idle();
        read_reg_1 = 5'd3;
        #1 check("rf_r3", rd_data_1, 32'd21);

        // Same register back-to-back: req1 first (req0 granted last), newest value forwarded.
        cyc(1'b0, 1'b1, 5'd7, 32'd70, 1'b1, 5'd7, 32'd71, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 5'd7, 32'd70, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        read_reg_0 = 5'd7;
        #1 check("fwd_r7_first", rd_data_0, 32'd71);
        idle();
        #1 check("fwd_r7_newest", rd_data_0, 32'd70);
        idle();
        #1 check("rf_r7", rd_data_0, 32'd70);

        // Reset right after granting r31: the issued write must be dropped.
        cyc(1'b0, 1'b1, 5'd31, 32'd13, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        void'(exp_q.pop_back());
        @(posedge cclk);
        #1 rst = 1'b1;
        #1 check("rst_drop_write", 32'(rf_write), 32'd0);
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        idle();
        read_reg_0 = 5'd31;
        #1 check("r31_unwritten", rd_data_0, 32'd31);

        repeat (3) @(negedge cclk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
